score_decision: RTL and testbench
=================================

Name: score_decision

Overview:
- Downstream of the fully-connected classifier stage; consumes its two-beat score stream: class-0 (non-smoking) score, then class-1 (smoking) score, on consecutive cycles.
- Computes the per-frame margin and the per-frame smoking decision.
- Applies run-length hysteresis across frames to drive a stable alarm output for the system/LED/UART stage.

Parameters:
- DW, 12, score width (signed two's complement).
- THRESH, 0, signed margin threshold; frame is smoking iff margin > THRESH (strict).
- ALARM_ON, 3, consecutive smoking frames required to raise alarm (range 1..2^CNT_W-1).
- ALARM_OFF, 2, consecutive non-smoking frames required to drop alarm (range 1..2^CNT_W-1).
- CNT_W, 4, width of run counters and frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  score beat valid; two consecutive beats per frame.
- data_in  in  DW  signed score; beat 1 = class 0, beat 2 = class 1.
- decision_valid  out  1  one-cycle pulse; margin/is_smoking/alarm updated.
- is_smoking  out  1  per-frame decision.
- margin  out  DW+1  signed (class1 - class0).
- alarm  out  1  hysteresis-filtered alarm level.
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W.
- seq_err  out  1  one-cycle pulse on broken beat pair.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; s0 latch 0; smoke_run and clear_run 0.
- FSM, two states:
  - IDLE: valid_in=1 -> latch data_in as s0, go WAIT_C1. valid_in=0 -> stay.
  - WAIT_C1: valid_in=1 -> compute frame, go IDLE. valid_in=0 -> seq_err=1 next cycle, discard s0, go IDLE; no decision, counters untouched.
- Frame compute, registered:
  - margin = sext(data_in) - sext(s0), DW+1 bits; never overflows.
  - is_smoking = (margin > sext(THRESH)). A tie is non-smoking.
- Latency: decision_valid asserts the cycle after the class-1 beat, for exactly one cycle. margin and is_smoking hold until the next decision.
- Back-to-back frames: valid_in held high for 4 cycles yields 2 frames. The beat arriving in IDLE always starts a new frame.
- Hysteresis, evaluated on each decision:
  - Smoking frame: smoke_run = sat_inc(smoke_run); clear_run = 0.
  - Non-smoking frame: clear_run = sat_inc(clear_run); smoke_run = 0.
  - Counters saturate at 2^CNT_W-1.
  - alarm set when the new smoke_run >= ALARM_ON; cleared when the new clear_run >= ALARM_OFF; otherwise held.
  - alarm changes in the same cycle decision_valid asserts.
- frame_cnt increments on every decision_valid and wraps to 0 after 2^CNT_W-1. It does not count seq_err frames.
- Reset mid-frame (in WAIT_C1) returns to IDLE, clears everything, and emits no pulse.
- A valid_in at the first cycle after reset deassertion is accepted as class 0.

Decomposition:
- Shared package (score_pkg): DW, score typedef (signed DW), margin typedef (signed DW+1), and the FSM state encoding IDLE/WAIT_C1.
- One natural sub-module: hyst_filter.
  - Owns smoke_run, clear_run and alarm.
  - Takes a decision strobe plus is_smoking; parameterised by ALARM_ON, ALARM_OFF and CNT_W.

Test Plan:
1. Beats -50, 100 -> one cycle after beat 2: decision_valid=1, margin=150, is_smoking=1, alarm=0, frame_cnt=1.
2. Three smoking frames back-to-back (valid_in high for 6 cycles) -> alarm rises on the 3rd decision_valid. Then two frames of 20, 20 (margin 0, tie) -> is_smoking=0, and alarm falls on the 2nd of those.
3. Extremes: -2048 then 2047 -> margin=4095, is_smoking=1. Then 2047 then -2048 -> margin=-4095, is_smoking=0.
4. A single valid beat (30) followed by a gap -> seq_err pulses once the cycle after the gap cycle; no decision_valid; frame_cnt and alarm unchanged. The next good pair decodes correctly.
5. Reset asserted in WAIT_C1 after beat 1 -> all outputs 0 immediately. The following pair 10, 5 gives margin=-5, is_smoking=0, frame_cnt=1.
6. 16 good frames -> frame_cnt wraps 15 -> 0. 20 consecutive smoking frames -> smoke_run saturates at 15 and alarm stays 1.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types for the score decision stage: score width, score/margin types, FSM states.
package score_pkg;

  localparam int DW = 12;

  typedef logic signed [DW-1:0] score_t;
  typedef logic signed [DW:0]   margin_t;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_C1 = 1'b1
  } state_t;

endpackage

// File: rtl/hyst_filter.sv
// Run-length hysteresis on per-frame smoking decisions, driving a stable alarm level.
module hyst_filter #(
  parameter int ALARM_ON  = 3,
  parameter int ALARM_OFF = 2,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic smoking,
  output logic alarm
);

  localparam logic [CNT_W-1:0] ON_LVL  = CNT_W'(ALARM_ON);
  localparam logic [CNT_W-1:0] OFF_LVL = CNT_W'(ALARM_OFF);

  logic [CNT_W-1:0] smoke_run, clear_run;
  logic [CNT_W-1:0] smoke_nxt, clear_nxt;
  logic             alarm_nxt;

  // Saturating run counters and alarm set/clear decision for the incoming frame
  always_comb begin
    smoke_nxt = smoke_run;
    clear_nxt = clear_run;
    alarm_nxt = alarm;
    if (strobe) begin
      if (smoking) begin
        smoke_nxt = (smoke_run == '1) ? smoke_run : smoke_run + 1'b1;
        clear_nxt = '0;
      end else begin
        clear_nxt = (clear_run == '1) ? clear_run : clear_run + 1'b1;
        smoke_nxt = '0;
      end
      if (smoke_nxt >= ON_LVL) begin
        alarm_nxt = 1'b1;
      end else if (clear_nxt >= OFF_LVL) begin
        alarm_nxt = 1'b0;
      end
    end
  end

  // Counter and alarm state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smoke_run <= '0;
      clear_run <= '0;
      alarm     <= 1'b0;
    end else begin
      smoke_run <= smoke_nxt;
      clear_run <= clear_nxt;
      alarm     <= alarm_nxt;
    end
  end

endmodule

// File: rtl/score_decision.sv
// Pairs class-0/class-1 score beats into frames, computes margin and smoking decision,
// and feeds the hysteresis filter that drives the alarm.
module score_decision #(
  parameter int DW        = score_pkg::DW,
  parameter int THRESH    = 0,
  parameter int ALARM_ON  = 3,
  parameter int ALARM_OFF = 2,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] data_in,
  output logic                 decision_valid,
  output logic                 is_smoking,
  output logic signed [DW:0]   margin,
  output logic                 alarm,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 seq_err
);

  import score_pkg::*;

  localparam logic signed [DW:0] THRESH_M = (DW+1)'(THRESH);

  state_t                state, state_nxt;
  logic signed [DW-1:0]  s0;
  logic signed [DW:0]    margin_nxt;
  logic                  frame_done;
  logic                  smoke_nxt;

  // Next state and frame-complete detection
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (valid_in) state_nxt = WAIT_C1;
      WAIT_C1: begin
        state_nxt  = IDLE;
        frame_done = valid_in;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Margin is one bit wider than a score so class1 - class0 can never overflow
  always_comb begin
    margin_nxt = $signed({data_in[DW-1], data_in}) - $signed({s0[DW-1], s0});
    smoke_nxt  = (margin_nxt > THRESH_M);
  end

  // FSM state, class-0 latch, frame outputs and one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      s0             <= '0;
      decision_valid <= 1'b0;
      is_smoking     <= 1'b0;
      margin         <= '0;
      frame_cnt      <= '0;
      seq_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      decision_valid <= 1'b0;
      seq_err        <= 1'b0;
      if (state == IDLE) begin
        if (valid_in) s0 <= data_in;
      end else if (frame_done) begin
        margin         <= margin_nxt;
        is_smoking     <= smoke_nxt;
        decision_valid <= 1'b1;
        frame_cnt      <= frame_cnt + 1'b1;
      end else begin
        seq_err <= 1'b1;
        s0      <= '0;
      end
    end
  end

  // Filter updates on the same edge that raises decision_valid, so alarm moves with it
  hyst_filter #(
    .ALARM_ON  (ALARM_ON),
    .ALARM_OFF (ALARM_OFF),
    .CNT_W     (CNT_W)
  ) u_hyst (
    .clk     (clk),
    .rst     (rst),
    .strobe  (frame_done),
    .smoking (smoke_nxt),
    .alarm   (alarm)
  );

endmodule

// File: tb/tb_score_decision.sv
// Scoreboard bench for score_decision: stimulus pushes expected events, monitor pops on output pulses.
module tb_score_decision;

  localparam int DW    = 12;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic signed [DW-1:0] data_in;
  logic                 decision_valid, is_smoking, alarm, seq_err;
  logic signed [DW:0]   margin;
  logic [CNT_W-1:0]     frame_cnt;

  typedef struct {
    bit kind;   // 0 = decision, 1 = seq_err
    int margin;
    int smk;
    int alarm;
    int fcnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  score_decision #(
    .DW        (DW),
    .THRESH    (0),
    .ALARM_ON  (3),
    .ALARM_OFF (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .decision_valid (decision_valid),
    .is_smoking     (is_smoking),
    .margin         (margin),
    .alarm          (alarm),
    .frame_cnt      (frame_cnt),
    .seq_err        (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".decision_valid"}, int'(decision_valid), 0);
    check({tag, ".is_smoking"},     int'(is_smoking), 0);
    check({tag, ".margin"},         int'(margin), 0);
    check({tag, ".alarm"},          int'(alarm), 0);
    check({tag, ".frame_cnt"},      int'(frame_cnt), 0);
    check({tag, ".seq_err"},        int'(seq_err), 0);
  endtask

  task automatic beat(input logic v, input int d);
    valid_in = v;
    data_in  = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int c0, input int c1, input int em, input int es,
                       input int ea, input int ef);
    exp_t e;
    e.kind = 1'b0; e.margin = em; e.smk = es; e.alarm = ea; e.fcnt = ef;
    q.push_back(e);
    beat(1'b1, c0);
    beat(1'b1, c1);
  endtask

  task automatic expect_seq_err(input int ea, input int ef);
    exp_t e;
    e.kind = 1'b1; e.margin = 0; e.smk = 0; e.alarm = ea; e.fcnt = ef;
    q.push_back(e);
  endtask

  // Monitor: every output pulse must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && (decision_valid || seq_err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: dv=%0b seq_err=%0b with empty queue", decision_valid, seq_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.kind == 1'b0) begin
          if (!(decision_valid && !seq_err && int'(margin) == e.margin &&
                int'(is_smoking) == e.smk && int'(alarm) == e.alarm &&
                int'(frame_cnt) == e.fcnt)) begin
            errors++;
            $display("FAIL decision: got dv=%0b se=%0b margin=%0d smk=%0b alarm=%0b fcnt=%0d expected dv=1 se=0 margin=%0d smk=%0d alarm=%0d fcnt=%0d",
                     decision_valid, seq_err, margin, is_smoking, alarm, frame_cnt,
                     e.margin, e.smk, e.alarm, e.fcnt);
          end
        end else begin
          if (!(seq_err && !decision_valid && int'(alarm) == e.alarm &&
                int'(frame_cnt) == e.fcnt)) begin
            errors++;
            $display("FAIL seq_err_event: got dv=%0b se=%0b alarm=%0b fcnt=%0d expected dv=0 se=1 alarm=%0d fcnt=%0d",
                     decision_valid, seq_err, alarm, frame_cnt, e.alarm, e.fcnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Basic frame, then a non-smoking frame to clear the smoke run
    frame(-50, 100, 150, 1, 0, 1);
    frame(20, 10, -10, 0, 0, 2);
    beat(1'b0, 0);

    // Three smoking frames back-to-back, then two ties
    frame(0, 5, 5, 1, 0, 3);
    frame(1, 9, 8, 1, 0, 4);
    frame(-3, 7, 10, 1, 1, 5);
    frame(20, 20, 0, 0, 1, 6);
    frame(20, 20, 0, 0, 0, 7);
    beat(1'b0, 0);

    // Extremes
    frame(-2048, 2047, 4095, 1, 0, 8);
    frame(2047, -2048, -4095, 0, 0, 9);
    beat(1'b0, 0);

    // Broken pair: single beat then gap
    expect_seq_err(0, 9);
    beat(1'b1, 30);
    beat(1'b0, 0);
    beat(1'b0, 0);
    frame(4, -6, -10, 0, 0, 10);
    beat(1'b0, 0);

    // Reset while waiting for class 1
    beat(1'b1, 7);
    rst = 1'b1; valid_in = 1'b0;
    #1;
    chk_zero("midframe_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame(10, 5, -5, 0, 0, 1);

    // 20 smoking frames: frame_cnt wraps, smoke run saturates, alarm holds
    for (int i = 1; i <= 20; i++) begin
      frame(0, 1, 1, 1, (i >= 3) ? 1 : 0, (1 + i) % 16);
    end
    beat(1'b0, 0);
    check("smoke_run_saturated", int'(dut.u_hyst.smoke_run), 15);

    repeat (3) beat(1'b0, 0);
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
